// File: rtl/mc_path_scheduler.sv
// Path/step sequencer for the Monte Carlo engine: issues engine loads, tracks indices, emits strobes.
// Optional per-step watchdog is built when MC_TIMEOUT_EN is defined.
module mc_path_scheduler #(
  parameter int NUM_STEPS      = 4,
  parameter int STEP_W         = 4,
  parameter int PATH_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PATH_W-1:0] cfg_paths,
  input  logic              engine_done,
  output logic              engine_load,
  output logic              busy,
  output logic [STEP_W-1:0] step_idx,
  output logic [PATH_W-1:0] path_idx,
  output logic              step_valid,
  output logic              path_valid,
  output logic              done,
  output logic              aborted,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    FINISH
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);
  localparam logic [PATH_W-1:0] ONE_PATH  = PATH_W'(1);

  state_t            state;
  logic [PATH_W-1:0] paths_lat;
  logic [PATH_W-1:0] last_path_idx;
  logic              last_step;
  logic              last_path;
  logic              wd_trip;

  assign last_path_idx = paths_lat - ONE_PATH;
  assign last_step     = (step_idx == LAST_STEP);
  assign last_path     = (path_idx == last_path_idx);

`ifdef MC_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            in_wait;

  assign in_wait = (state == WAIT_LO) || (state == WAIT_HI);
  assign wd_trip = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // ISSUE always precedes WAIT_LO, so clearing there restarts the count for every step
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ISSUE) begin
      wd_cnt <= '0;
    end else if (in_wait && !wd_trip) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign wd_trip     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      paths_lat   <= '0;
      engine_load <= 1'b0;
      busy        <= 1'b0;
      step_idx    <= '0;
      path_idx    <= '0;
      step_valid  <= 1'b0;
      path_valid  <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
`ifdef MC_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      engine_load <= 1'b0;
      step_valid  <= 1'b0;
      path_valid  <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;

      if (state != IDLE && abort) begin
        state   <= IDLE;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else if (wd_trip) begin
        state   <= IDLE;
        busy    <= 1'b0;
        aborted <= 1'b1;
`ifdef MC_TIMEOUT_EN
        timeout_err <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy      <= 1'b1;
              step_idx  <= '0;
              path_idx  <= '0;
              paths_lat <= cfg_paths;
`ifdef MC_TIMEOUT_EN
              timeout_err <= 1'b0;
`endif
              if (cfg_paths != '0) begin
                state       <= ISSUE;
                engine_load <= 1'b1;
              end else begin
                state <= FINISH;
              end
            end
          end

          // Indices advance one cycle late so they still name the completed step while step_valid is high
          ISSUE: begin
            state <= WAIT_LO;
            if (step_valid) begin
              if (last_step) begin
                step_idx <= '0;
                path_idx <= path_idx + 1'b1;
              end else begin
                step_idx <= step_idx + 1'b1;
              end
            end
          end

          WAIT_LO: begin
            if (!engine_done) begin
              state <= WAIT_HI;
            end
          end

          WAIT_HI: begin
            if (engine_done) begin
              step_valid <= 1'b1;
              if (last_step) begin
                path_valid <= 1'b1;
                if (last_path) begin
                  state <= FINISH;
                end else begin
                  state       <= ISSUE;
                  engine_load <= 1'b1;
                end
              end else begin
                state       <= ISSUE;
                engine_load <= 1'b1;
              end
            end
          end

          FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            if (step_valid) begin
              step_idx <= '0;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mc_path_scheduler.md
Name: mc_path_scheduler

Overview:
- Top-level sequencer for the Monte Carlo simulation engine controller.
- Runs cfg_paths paths of NUM_STEPS time steps each by pulsing the engine's load and waiting for its done.
- Tracks step and path indices and emits per-step and per-path strobes for the downstream accumulator and payoff logic.
- Sits between the host/config interface and the sim engine control block.

Parameters:
- NUM_STEPS, 4: time steps per path; legal range 1..2^STEP_W.
- STEP_W, 4: width of step_idx.
- PATH_W, 8: width of cfg_paths and path_idx.
- TIMEOUT_CYCLES, 64: watchdog limit per engine step. Used only when MC_TIMEOUT_EN is defined.

Ports:
- clk, input, 1: single system clock; all logic rising-edge.
- rst, input, 1: synchronous reset, active-high.
- start, input, 1: begin a run; sampled only in IDLE.
- abort, input, 1: cancel the run; valid in any state.
- cfg_paths, input, PATH_W: number of paths; captured when start is accepted.
- engine_done, input, 1: sim engine done. High when the engine is idle; low while it is computing.
- engine_load, output, 1: one-cycle pulse that launches one engine step.
- busy, output, 1: high from start accepted until return to IDLE.
- step_idx, output, STEP_W: index of the step currently in flight.
- path_idx, output, PATH_W: index of the path currently in flight.
- step_valid, output, 1: one-cycle pulse when a step completes.
- path_valid, output, 1: one-cycle pulse when the last step of a path completes.
- done, output, 1: one-cycle pulse at run completion.
- aborted, output, 1: one-cycle pulse when an abort is taken.
- timeout_err, output, 1: sticky watchdog error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0 and the indices are cleared.
  - rst takes priority over all other inputs, including mid-run.
- Output timing: all outputs are registered. Every strobe is high for exactly one cycle.
- IDLE:
  - busy=0.
  - start=1 with cfg_paths!=0: latch cfg_paths, clear the indices, set busy=1, go to ISSUE.
  - start=1 with cfg_paths==0: go to FINISH. No engine_load is ever issued.
- ISSUE:
  - Drive engine_load=1 for this one cycle.
  - Go to WAIT_LO.
- WAIT_LO: wait for engine_done==0, i.e. the engine has accepted the load. Then go to WAIT_HI.
- WAIT_HI: on engine_done==1:
  - Pulse step_valid in the next cycle, with step_idx and path_idx still showing the completed step.
  - If this was not the last step (step_idx != NUM_STEPS-1): increment step_idx and go to ISSUE.
  - If it was the last step of a path: also pulse path_valid, set step_idx=0, then:
    - more paths remain (path_idx != latched_paths-1): increment path_idx and go to ISSUE;
    - last path: go to FINISH.
- FINISH:
  - Pulse done, return to IDLE, drop busy in the same cycle.
  - path_idx and step_idx hold their final values until the next start.
- Minimum step period: ISSUE, WAIT_LO, WAIT_HI = 3 cycles plus engine latency.
- start while busy is ignored. It is neither queued nor able to reload cfg_paths.
- Changes to cfg_paths mid-run have no effect.
- Abort:
  - abort=1 in any non-IDLE state: next state is IDLE, aborted pulses, busy=0.
  - No step_valid, path_valid or done is issued for the partial step.
  - abort in IDLE is ignored.
  - abort and engine_done rising in the same cycle: abort wins, no strobes.
  - start and abort high together in IDLE: start is taken.
- Index arithmetic:
  - Indices are unsigned.
  - Comparisons use the latched path count minus 1, computed at PATH_W width.
  - With cfg_paths = 2^PATH_W - 1, path_idx reaches 2^PATH_W - 2 and never wraps.

Optional Feature:
- Macro: MC_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_LO and counts each cycle spent in WAIT_LO or WAIT_HI.
  - When it reaches TIMEOUT_CYCLES: set timeout_err=1 (sticky), pulse aborted, go to IDLE.
  - timeout_err clears only on rst or on the next accepted start.
- When undefined:
  - No counter is built; WAIT states wait indefinitely.
  - timeout_err is tied to 0.

Test Plan:
1. rst held 2 cycles, then released: busy, engine_load, done, step_valid, path_valid and aborted are all 0; step_idx=0, path_idx=0.
2. Engine model returns done 3 cycles after load; NUM_STEPS=4, cfg_paths=3, pulse start:
   - exactly 12 engine_load pulses and 12 step_valid pulses;
   - path_valid at step_idx=3 for path_idx=0, 1, 2;
   - one done pulse, then busy=0.
3. start with cfg_paths=0: done pulses 2 cycles later; no engine_load; busy is high for only that window.
4. Abort:
   - abort during WAIT_HI of path 1 step 2: aborted pulses, busy=0 next cycle, no step_valid;
   - a new start with cfg_paths=1 then yields 4 loads and done.
5. start re-pulsed mid-run with cfg_paths=9, original run cfg_paths=2: the run still completes after 8 steps with a single done.
6. With MC_TIMEOUT_EN and TIMEOUT_CYCLES=64, engine_done held low forever:
   - after 64 wait cycles, timeout_err=1 and aborted pulses;
   - timeout_err stays 1 until the next start, which clears it.
